// File: rtl/imem_loader_pkg.sv
// imem_loader shared types and defaults.
// Load FSM states, default geometry, count limit.
package imem_pkg;

  typedef enum logic [1:0] {
    IMEM_EMPTY,
    IMEM_LOAD,
    IMEM_READY
  } imem_state_e;

  localparam int IMEM_DATA_W = 8;
  localparam int IMEM_DEPTH  = 16;

  // Largest value an (addr_w+1)-bit counter holds.
  function automatic int cnt_max(input int addr_w);
    return (1 << (addr_w + 1)) - 1;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader load and fetch bus.
// master = loader/fetch side, slave = memory.
interface imem_loader_if
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int ADDR_W = $clog2(IMEM_DEPTH)
);

  logic              load_start;
  logic              load_end;
  logic              ld_valid;
  logic              ld_ready;
  logic              ld_auto;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ovf;
  logic [ADDR_W:0]   ld_count;
  logic              fetch_req;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_pc;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  modport master (
    output load_start, load_end,
    output ld_valid, ld_auto,
    output ld_addr, ld_data,
    output fetch_req, fetch_pc,
    input  ld_ready, ld_ovf, ld_count,
    input  fetch_ready, fetch_valid,
    input  fetch_data, fetch_err
  );

  modport slave (
    input  load_start, load_end,
    input  ld_valid, ld_auto,
    input  ld_addr, ld_data,
    input  fetch_req, fetch_pc,
    output ld_ready, ld_ovf, ld_count,
    output fetch_ready, fetch_valid,
    output fetch_data, fetch_err
  );

endinterface

// File: rtl/imem_loader_array.sv
// Word storage, valid bitmap and
// registered read port for imem_loader.
module imem_array
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_err
);

  localparam logic [ADDR_W:0] DEPTH_L =
    DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  vld_q, vld_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_err_q, rd_err_d;
  logic              rd_oob;
  logic [ADDR_W-1:0] rd_idx;

  // Storage is never reset; caller keeps wr_addr in range.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Bitmap: set on write, clear on a new load (clear wins).
  always_comb begin
    vld_d = vld_q;
    if (we) vld_d[wr_addr] = 1'b1;
    if (clr) vld_d = '0;
  end

  // Read response: out-of-range gives zero data and error.
  always_comb begin
    rd_oob    = {1'b0, rd_addr} >= DEPTH_L;
    rd_idx    = rd_oob ? '0 : rd_addr;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    if (re) begin
      rd_data_d = rd_oob ? '0 : mem[rd_idx];
      rd_err_d  = rd_oob | ~vld_q[rd_idx];
    end
  end

  // Bitmap and read-response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      vld_q     <= vld_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_err  = rd_err_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction memory with program-load FSM
// and one-cycle handshaked fetch port.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = IMEM_DATA_W,
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH_L =
    DEPTH[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_A =
    DEPTH_L[ADDR_W-1:0] - 1'b1;
  localparam int CNT_MAX_I = cnt_max(ADDR_W);
  localparam logic [ADDR_W:0] CNT_MAX =
    CNT_MAX_I[ADDR_W:0];

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              fv_q, fv_d;

  logic              ld_rdy;
  logic              f_rdy;
  logic              wr_fire;
  logic              wr_oob;
  logic              we;
  logic [ADDR_W-1:0] wr_addr;
  logic              f_acc;

  // FSM, write pointer, counters and handshakes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    ld_rdy  = state_q == IMEM_LOAD;
    f_rdy   = state_q == IMEM_READY;
    f_acc   = bus.fetch_req & f_rdy;
    fv_d    = f_acc;
    wr_fire = bus.ld_valid & ld_rdy;
    wr_oob  = ~bus.ld_auto &
              ({1'b0, bus.ld_addr} >= DEPTH_L);
    we      = wr_fire & ~wr_oob;
    wr_addr = bus.ld_auto ? ptr_q : bus.ld_addr;

    if (we) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (bus.ld_auto) begin
        if (ptr_q == LAST_A) begin
          ptr_d = '0;
          ovf_d = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
    end
    if (wr_fire & wr_oob) ovf_d = 1'b1;

    unique case (1'b1)
      bus.load_start: begin
        state_d = IMEM_LOAD;
        ptr_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      bus.load_end & ld_rdy & ~bus.load_start:
        state_d = IMEM_READY;
      default: ;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IMEM_EMPTY;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fv_q    <= fv_d;
    end
  end

  imem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (bus.load_start),
    .we      (we),
    .wr_addr (wr_addr),
    .wr_data (bus.ld_data),
    .re      (f_acc),
    .rd_addr (bus.fetch_pc),
    .rd_data (bus.fetch_data),
    .rd_err  (bus.fetch_err)
  );

  assign bus.ld_ready    = ld_rdy;
  assign bus.fetch_ready = f_rdy;
  assign bus.fetch_valid = fv_q;
  assign bus.ld_ovf      = ovf_q;
  assign bus.ld_count    = cnt_q;

endmodule
